ps2_autotyper: RTL and testbench
================================

Name: ps2_autotyper

Overview:
- Upstream stimulus stage for the orao core's PS/2 keyboard input (ps2clk/ps2data), replacing the tied-off 1'b1 inputs.
- Emulates a PS/2 keyboard (device-driven clock) and plays a fixed scan-code script, so button-less boards boot into BASIC by typing B, C, Enter x3.
- Runs once automatically after reset, and again on each start pulse.

Parameters:
- CLK_MHZ, 25, system clock frequency in MHz
- PS2_KHZ, 12, PS/2 bit rate in kHz; HALF = (CLK_MHZ*1000)/(2*PS2_KHZ) clocks, integer division; 1041 at defaults
- SCRIPT_LEN, 5, number of script entries, 1..32
- SCRIPT, 40'h5A5A5A2132, packed make codes; entry i = SCRIPT[8i+7:8i], entry 0 sent first
- STARTUP_HALVES, 2400, half-periods of idle after reset before the auto run
- GAP_HALVES, 24, idle half-periods after every byte
- AUTO_START, 1, 1 = run the script once after reset; 0 = wait for start

Ports:
- clk  in  1  system clock (pixel clock domain)
- n_reset  in  1  asynchronous active-low reset
- start  in  1  synchronous level; rising edge (clk-sampled) requests a script run
- ps2clk  out  1  emulated keyboard clock, idle 1
- ps2data  out  1  emulated keyboard data, idle 1
- busy  out  1  high while a script run is in progress (startup wait included)
- done  out  1  high from end of a run until the next run starts
- byte_count  out  8  bytes fully sent in current run

Behaviour:
- Reset (async, n_reset=0): ps2clk=1, ps2data=1, busy=0, done=0, byte_count=0, FSM=IDLE, start edge detector cleared.
- A half-period counter counts 0..HALF-1; all phase timing is in whole half-periods.
- FSM states: IDLE, STARTUP, LOAD, BIT_HI, BIT_LO, GAP, FINISH.
- IDLE: after reset, if AUTO_START=1 go to STARTUP (busy=1). Otherwise wait for a start rising edge, then go to LOAD (busy=1, done=0, byte_count=0, entry index=0).
- STARTUP: hold idle lines for STARTUP_HALVES half-periods, then go to LOAD.
- LOAD (1 clock): build an 11-bit shift register {stop=1, parity, data[7:0], start=0}, sent LSB first.
  - parity = ~^data (odd parity).
  - Bit counter = 0.
- BIT_HI: ps2data = current bit, ps2clk=1, for HALF clocks. Then go to BIT_LO.
- BIT_LO: ps2clk=0, ps2data held, for HALF clocks. The host samples on the ps2clk falling edge; data is stable for a full half-period before and during the low phase.
  - After the low phase, if bit counter < 10: increment it, shift, go to BIT_HI.
  - Otherwise go to GAP with ps2clk=1, ps2data=1, and byte_count+1.
- GAP: idle lines for GAP_HALVES half-periods. Then go to LOAD with the next byte, or to FINISH if the script is exhausted.
- FINISH (1 clock): busy=0, done=1, back to IDLE. Further runs need a start edge, regardless of AUTO_START.
- Frame length: 22*HALF clocks from LOAD exit to GAP entry.
- start edge while busy=1: ignored, not queued.
- Reset mid-frame: lines return to 1 immediately (async); the partial byte is abandoned and never resumed.
- byte_count saturates at 255.
- Byte ordering without break codes: entry 0..SCRIPT_LEN-1, one byte each.

Optional Feature:
- Macro: PS2_AUTOTYPER_BREAK_EN.
- Defined: each entry emits three bytes, each followed by its own GAP: make, 8'hF0, make (key release). A run is 3*SCRIPT_LEN bytes; byte_count counts all of them.
- Undefined: make codes only; SCRIPT_LEN bytes per run.

Test Plan:
- Frame timing/format. Setup: CLK_MHZ=1, PS2_KHZ=250 (HALF=2), AUTO_START=0, SCRIPT_LEN=1, SCRIPT=8'h32. Stimulus: pulse start. Required:
  - first ps2clk fall 2 clocks after LOAD exit;
  - 11 falls, 4 clocks apart;
  - sampled bits 0,0,1,0,0,1,1,0,0,0,1 (parity 0 for 0x32, three ones);
  - done=1 after GAP; byte_count=1.
- Default script, auto start. Setup: AUTO_START=1, HALF=2, STARTUP_HALVES=4. Stimulus: release reset. Required: first LOAD after 8 clocks; decoded bytes 32,21,5A,5A,5A; busy falls; done=1; byte_count=5.
- Parity check. Stimulus: byte 8'h00, then 8'hFF. Required: parity bit 1 for 8'h00, 1 for 8'hFF; stop bit 1 on both.
- Start while busy. Stimulus: pulse start mid-frame of byte 2. Required: run completes with exactly 5 bytes. A later start after done → new run; done drops and byte_count resets to 0 on the first clock of the new run.
- Reset mid-frame. Stimulus: assert n_reset during BIT_LO. Required: ps2clk=1, ps2data=1, busy=0 in the same cycle. Rerun restarts from entry 0.
- PS2_AUTOTYPER_BREAK_EN defined, SCRIPT_LEN=1, SCRIPT=8'h5A. Required: bytes 5A,F0,5A with a GAP after each; byte_count=3.

Source files
------------

// File: rtl/ps2_autotyper.sv
// PS/2 keyboard emulator that types a fixed scan-code script after reset and on each start edge.
// Define PS2_AUTOTYPER_BREAK_EN to follow every make code with F0 + make (key release).
module ps2_autotyper #(
    parameter int           CLK_MHZ        = 25,
    parameter int           PS2_KHZ        = 12,
    parameter int           SCRIPT_LEN     = 5,
    parameter logic [255:0] SCRIPT         = 256'h5A5A5A2132,
    parameter int           STARTUP_HALVES = 2400,
    parameter int           GAP_HALVES     = 24,
    parameter int           AUTO_START     = 1
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start,
    output logic       ps2clk,
    output logic       ps2data,
    output logic       busy,
    output logic       done,
    output logic [7:0] byte_count
);

    localparam int          HALF         = (CLK_MHZ * 1000) / (2 * PS2_KHZ);
    localparam logic [15:0] HALF_LAST    = 16'(HALF - 1);
    localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_HALVES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_HALVES - 1);
    localparam logic [4:0]  IDX_LAST     = 5'(SCRIPT_LEN - 1);
`ifdef PS2_AUTOTYPER_BREAK_EN
    localparam logic [1:0]  SUB_LAST     = 2'd2;
`else
    localparam logic [1:0]  SUB_LAST     = 2'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_STARTUP, S_LOAD, S_BIT_HI, S_BIT_LO, S_GAP, S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] halves_q, halves_d;
    logic [3:0]  bitn_q, bitn_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  sub_q, sub_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        auto_q, auto_d;
    logic        start_q;
    logic [10:0] frame_q;
    logic        load_en, shift_en;
    logic        half_end, start_rise;
    logic [7:0]  byte_sel;

    assign half_end   = (hcnt_q == HALF_LAST);
    assign start_rise = start & ~start_q;

    // sub_q selects make / F0 / make within one script entry when releases are enabled
`ifdef PS2_AUTOTYPER_BREAK_EN
    assign byte_sel = (sub_q == 2'd1) ? 8'hF0 : SCRIPT[{idx_q, 3'b000} +: 8];
`else
    assign byte_sel = SCRIPT[{idx_q, 3'b000} +: 8];
`endif

    always_comb begin
        state_d  = state_q;
        hcnt_d   = 16'd0;
        halves_d = halves_q;
        bitn_d   = bitn_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        auto_d   = auto_q;
        load_en  = 1'b0;
        shift_en = 1'b0;

        if (state_q inside {S_STARTUP, S_BIT_HI, S_BIT_LO, S_GAP})
            hcnt_d = half_end ? 16'd0 : hcnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                idx_d    = 5'd0;
                sub_d    = 2'd0;
                halves_d = 16'd0;
                if (auto_q) begin
                    auto_d  = 1'b0;
                    state_d = S_STARTUP;
                end else if (start_rise) begin
                    done_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_LOAD;
                end
            end
            S_STARTUP: begin
                if (half_end) begin
                    if (halves_q == STARTUP_LAST) begin
                        halves_d = 16'd0;
                        state_d  = S_LOAD;
                    end else begin
                        halves_d = halves_q + 16'd1;
                    end
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                bitn_d  = 4'd0;
                state_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (half_end) state_d = S_BIT_LO;
            end
            S_BIT_LO: begin
                if (half_end) begin
                    if (bitn_q != 4'd10) begin
                        bitn_d   = bitn_q + 4'd1;
                        shift_en = 1'b1;
                        state_d  = S_BIT_HI;
                    end else begin
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (half_end) begin
                    if (halves_q == GAP_LAST) begin
                        halves_d = 16'd0;
                        if (sub_q != SUB_LAST) begin
                            sub_d   = sub_q + 2'd1;
                            state_d = S_LOAD;
                        end else if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            sub_d   = 2'd0;
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        halves_d = halves_q + 16'd1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            hcnt_q   <= 16'd0;
            halves_q <= 16'd0;
            bitn_q   <= 4'd0;
            idx_q    <= 5'd0;
            sub_q    <= 2'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
            auto_q   <= (AUTO_START != 0);
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            halves_q <= halves_d;
            bitn_q   <= bitn_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            auto_q   <= auto_d;
            start_q  <= start;
        end
    end

    // Frame is {stop, odd parity, data, start}, shifted out LSB first; only observed in bit states
    always_ff @(posedge clk) begin
        if (load_en)
            frame_q <= {1'b1, ~^byte_sel, byte_sel, 1'b0};
        else if (shift_en)
            frame_q <= {1'b1, frame_q[10:1]};
    end

    assign ps2clk     = (state_q != S_BIT_LO);
    assign ps2data    = (state_q inside {S_BIT_HI, S_BIT_LO}) ? frame_q[0] : 1'b1;
    assign busy       = state_q inside {S_STARTUP, S_LOAD, S_BIT_HI, S_BIT_LO, S_GAP};
    assign done       = done_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_ps2_autotyper.sv
// Directed bench for ps2_autotyper: a manual-start instance (frame format/parity) and an auto-start instance.
module tb_ps2_autotyper;

`ifdef PS2_AUTOTYPER_BREAK_EN
    localparam int MULT = 3;
`else
    localparam int MULT = 1;
`endif
    localparam int NM = 3 * MULT;
    localparam int NA = 5 * MULT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m = 1'b0, start_m = 1'b0;
    logic pc_m, pd_m, busy_m, done_m;
    logic [7:0] bc_m;
    logic rst_a = 1'b0, start_a = 1'b0;
    logic pc_a, pd_a, busy_a, done_a;
    logic [7:0] bc_a;

    ps2_autotyper #(.CLK_MHZ(1), .PS2_KHZ(250), .SCRIPT_LEN(3), .SCRIPT(256'hFF0032),
                    .STARTUP_HALVES(4), .GAP_HALVES(3), .AUTO_START(0)) u_man (
        .clk(clk), .n_reset(rst_m), .start(start_m), .ps2clk(pc_m), .ps2data(pd_m),
        .busy(busy_m), .done(done_m), .byte_count(bc_m));

    ps2_autotyper #(.CLK_MHZ(1), .PS2_KHZ(250), .SCRIPT_LEN(5), .SCRIPT(256'h5A5A5A2132),
                    .STARTUP_HALVES(4), .GAP_HALVES(2), .AUTO_START(1)) u_auto (
        .clk(clk), .n_reset(rst_a), .start(start_a), .ps2clk(pc_a), .ps2data(pd_a),
        .busy(busy_a), .done(done_a), .byte_count(bc_a));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic bits_m[$], bits_a[$];
    int   falls_m[$], falls_a[$];
    logic pcm_prev = 1'b1, pca_prev = 1'b1;
    always @(negedge clk) begin
        if (pcm_prev && !pc_m) begin bits_m.push_back(pd_m); falls_m.push_back(cyc); end
        if (pca_prev && !pc_a) begin bits_a.push_back(pd_a); falls_a.push_back(cyc); end
        pcm_prev <= pc_m;
        pca_prev <= pc_a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_frames(input string tag, input logic b[$], input logic [7:0] ex[$]);
        logic [7:0] d;
        chk({tag, "_bits_len"}, b.size(), 11 * ex.size());
        for (int k = 0; k < ex.size(); k++) begin
            if (b.size() >= 11 * (k + 1)) begin
                for (int j = 0; j < 8; j++) d[j] = b[11*k+1+j];
                chk($sformatf("%s_start%0d", tag, k), b[11*k], 1'b0);
                chk($sformatf("%s_data%0d", tag, k), d, ex[k]);
                chk($sformatf("%s_par%0d", tag, k), b[11*k+9], ~^ex[k]);
                chk($sformatf("%s_stop%0d", tag, k), b[11*k+10], 1'b1);
            end
        end
    endtask

    typedef struct {
        int         frame;
        logic [7:0] data;
        logic       par;
    } vec_t;

    initial begin
        vec_t vm[3];
        logic seq32[11];
        logic [7:0] ent_m[3];
        logic [7:0] ent_a[5];
        logic [7:0] exp_m[$], exp_a[$];
        int n, t_busy, sz;

        vm[0] = '{0,        8'h32, 1'b0};
        vm[1] = '{1 * MULT, 8'h00, 1'b1};
        vm[2] = '{2 * MULT, 8'hFF, 1'b1};
        seq32 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ent_m = '{8'h32, 8'h00, 8'hFF};
        ent_a = '{8'h32, 8'h21, 8'h5A, 8'h5A, 8'h5A};
        foreach (ent_m[i]) begin
            exp_m.push_back(ent_m[i]);
`ifdef PS2_AUTOTYPER_BREAK_EN
            exp_m.push_back(8'hF0);
            exp_m.push_back(ent_m[i]);
`endif
        end
        foreach (ent_a[i]) begin
            exp_a.push_back(ent_a[i]);
`ifdef PS2_AUTOTYPER_BREAK_EN
            exp_a.push_back(8'hF0);
            exp_a.push_back(ent_a[i]);
`endif
        end

        // Reset state of both instances
        repeat (3) @(negedge clk);
        chk("rst_ps2clk_m", pc_m, 1'b1);   chk("rst_ps2data_m", pd_m, 1'b1);
        chk("rst_busy_m", busy_m, 1'b0);   chk("rst_done_m", done_m, 1'b0);
        chk("rst_count_m", bc_m, 8'd0);
        chk("rst_ps2clk_a", pc_a, 1'b1);   chk("rst_ps2data_a", pd_a, 1'b1);
        chk("rst_busy_a", busy_a, 1'b0);   chk("rst_done_a", done_a, 1'b0);
        chk("rst_count_a", bc_a, 8'd0);

        // Manual instance: one start pulse, frame timing, bit order and parity table
        rst_m = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_auto_m", busy_m, 1'b0);
        start_m = 1'b1;
        n = 0;
        while (!busy_m && n < 10) begin @(negedge clk); n++; end
        chk("busy_rise_m", busy_m, 1'b1);
        t_busy = cyc;
        chk("run_done_low_m", done_m, 1'b0);
        start_m = 1'b0;
        n = 0;
        while (!done_m && n < 3000) begin @(negedge clk); n++; end
        chk("done_m", done_m, 1'b1);
        chk("busy_end_m", busy_m, 1'b0);
        chk("count_m", bc_m, NM);
        chk("falls_m", falls_m.size(), 11 * NM);
        if (falls_m.size() >= 12) begin
            chk("first_fall_m", falls_m[0] - t_busy, 3);
            for (int i = 1; i < 11; i++)
                chk($sformatf("fall_spacing_%0d", i), falls_m[i] - falls_m[i-1], 4);
            chk("interframe_m", falls_m[11] - falls_m[10], 11);
        end
        if (bits_m.size() >= 11)
            for (int i = 0; i < 11; i++)
                chk($sformatf("seq32_bit%0d", i), bits_m[i], seq32[i]);
        for (int v = 0; v < 3; v++) begin
            if (bits_m.size() >= 11 * (vm[v].frame + 1)) begin
                chk($sformatf("vec%0d_par", v), bits_m[11*vm[v].frame+9], vm[v].par);
                chk($sformatf("vec%0d_stop", v), bits_m[11*vm[v].frame+10], 1'b1);
            end
        end
        check_frames("man", bits_m, exp_m);

        // Auto instance: startup wait, script bytes, start ignored while busy
        @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin @(negedge clk); n++; end
        chk("auto_busy_rise", busy_a, 1'b1);
        t_busy = cyc;
        n = 0;
        while (bits_a.size() < 16 && n < 3000) begin @(negedge clk); n++; end
        chk("mid_byte2_reached", bits_a.size() >= 16, 1'b1);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 5000) begin @(negedge clk); n++; end
        chk("done_a", done_a, 1'b1);
        chk("busy_end_a", busy_a, 1'b0);
        chk("count_a", bc_a, NA);
        if (falls_a.size() > 0) chk("auto_first_fall", falls_a[0] - t_busy, 11);
        check_frames("auto", bits_a, exp_a);
        sz = bits_a.size();
        repeat (20) @(negedge clk);
        chk("no_queued_run_busy", busy_a, 1'b0);
        chk("no_queued_run_bits", bits_a.size(), sz);

        // New run: done drops and count clears on its first clock
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("rerun_busy", busy_a, 1'b1);
        chk("rerun_done", done_a, 1'b0);
        chk("rerun_count", bc_a, 8'd0);

        // Reset during the low phase of a start bit
        n = 0;
        while (!(pc_a == 1'b0 && pd_a == 1'b0) && n < 200) begin @(negedge clk); n++; end
        chk("reached_bit_lo", {pc_a, pd_a}, 2'b00);
        rst_a = 1'b0;
        #1;
        chk("midrst_ps2clk", pc_a, 1'b1);
        chk("midrst_ps2data", pd_a, 1'b1);
        chk("midrst_busy", busy_a, 1'b0);
        @(negedge clk);
        bits_a.delete();
        falls_a.delete();
        rst_a = 1'b1;
        n = 0;
        while (!done_a && n < 5000) begin @(negedge clk); n++; end
        chk("after_rst_done", done_a, 1'b1);
        chk("after_rst_count", bc_a, NA);
        check_frames("after_rst", bits_a, exp_a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
